// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write port: geometry, FSM encoding
// and the row-address range check used by the arbiter top.
package regfile_write_arbiter_pkg;

    localparam int DATA_W   = 13;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 5;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return int'(addr) < NUM_REGS;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a requester masked as ineligible never wins,
// and on contention the requester not granted most recently wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic       last_q;   // index of the most recent winner
    logic [1:0] elig;

    assign elig = req & ~mask & {2{en}};

    always_comb begin
        gnt = elig;
        if (elig == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    // Reset value 1 makes client 0 the favoured side after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file's single write port: arbitrates two clients
// round-robin and runs a clear-all sequence that zeroes every row.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              CLRN,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              err,
    output logic [ADDR_W-1:0] WA,
    output logic [DATA_W-1:0] LD_DATA,
    output logic              WR,
    output state_t            dbg_state
);

    // Handshake: reqN is a level held with addrN/dataN stable until gntN is seen;
    // gntN is a one-cycle pulse, and a client granted this cycle cannot win at
    // the closing edge, so a req dropped in the gnt cycle never double-writes.

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              gnt0_d, gnt1_d, err_d, wr_d, busy_d;
    logic [ADDR_W-1:0] wa_d;
    logic [DATA_W-1:0] ld_d;
    logic              arb_en;
    logic [1:0]        win;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // The final clear edge already arbitrates, so a waiting client is granted
    // in the very first cycle after clr_busy drops.
    assign arb_en = (state_q == ST_IDLE && !clr_req) ||
                    (state_q == ST_CLEAR && cnt_q == LAST_ROW);

    rr_arbiter2 u_arb (
        .clk   (CLK),
        .rst_n (CLRN),
        .en    (arb_en),
        .req   ({req1, req0}),
        .mask  ({gnt1, gnt0}),
        .gnt   (win)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        err_d    = 1'b0;
        wr_d     = 1'b0;
        busy_d   = 1'b0;
        wa_d     = WA;
        ld_d     = LD_DATA;
        win_addr = win[1] ? addr1 : addr0;
        win_data = win[1] ? data1 : data0;

        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    wr_d    = 1'b1;
                    wa_d    = '0;
                    ld_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ROW) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    wr_d   = 1'b1;
                    wa_d   = cnt_q + 1'b1;
                    ld_d   = '0;
                    busy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (|win) begin
            gnt0_d = win[0];
            gnt1_d = win[1];
            if (addr_valid(win_addr)) begin
                wr_d = 1'b1;
                wa_d = win_addr;
                ld_d = win_data;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            err      <= 1'b0;
            WR       <= 1'b0;
            clr_busy <= 1'b0;
            WA       <= '0;
            LD_DATA  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt0     <= gnt0_d;
            gnt1     <= gnt1_d;
            err      <= err_d;
            WR       <= wr_d;
            clr_busy <= busy_d;
            WA       <= wa_d;
            LD_DATA  <= ld_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model and a bench-side register file.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic              CLK = 1'b0;
    logic              CLRN = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0, clr_req = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] data0 = '0, data1 = '0;
    logic              gnt0, gnt1, clr_busy, err, WR;
    logic [ADDR_W-1:0] WA;
    logic [DATA_W-1:0] LD_DATA;
    state_t            dbg_state;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    regfile_write_arbiter dut (
        .CLK(CLK), .CLRN(CLRN),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .clr_req(clr_req), .clr_busy(clr_busy), .err(err),
        .WA(WA), .LD_DATA(LD_DATA), .WR(WR), .dbg_state(dbg_state)
    );

    // Bench-side register file driven by the DUT write port.
    logic [DATA_W-1:0] tb_rf [NUM_REGS];
    always @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            for (int i = 0; i < NUM_REGS; i++) tb_rf[i] <= '0;
        end else if (WR && int'(WA) < NUM_REGS) begin
            tb_rf[WA] <= LD_DATA;
        end
    end

    // Reference model state.
    logic              exp_gnt0, exp_gnt1, exp_err, exp_wr, exp_busy;
    logic [ADDR_W-1:0] exp_wa;
    logic [DATA_W-1:0] exp_ld;
    int                m_last;    // client granted most recently
    int                m_rem;     // clear rows still to issue
    logic [DATA_W-1:0] m_rf [NUM_REGS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        exp_gnt0 = 0; exp_gnt1 = 0; exp_err = 0; exp_wr = 0; exp_busy = 0;
        exp_wa = '0; exp_ld = '0;
        m_last = 1; m_rem = 0;
        for (int i = 0; i < NUM_REGS; i++) m_rf[i] = '0;
    endtask

    // One clock edge of the specified behaviour, from the inputs seen at the edge.
    task automatic model_edge();
        logic prev_busy, pg0, pg1, e0, e1;
        int w, a;
        if (exp_wr) m_rf[exp_wa] = exp_ld;
        prev_busy = exp_busy; pg0 = exp_gnt0; pg1 = exp_gnt1;
        exp_gnt0 = 0; exp_gnt1 = 0; exp_err = 0; exp_wr = 0; exp_busy = 0;
        if (m_rem > 0) begin
            exp_wr = 1; exp_busy = 1; exp_wa = ADDR_W'(NUM_REGS - m_rem); exp_ld = '0;
            m_rem--;
        end else if (clr_req && !prev_busy) begin
            exp_wr = 1; exp_busy = 1; exp_wa = '0; exp_ld = '0;
            m_rem = NUM_REGS - 1;
        end else begin
            e0 = req0 && !pg0;
            e1 = req1 && !pg1;
            w = -1;
            if (e0 && e1) w = (m_last == 1) ? 0 : 1;
            else if (e0) w = 0;
            else if (e1) w = 1;
            if (w >= 0) begin
                m_last = w;
                if (w == 0) exp_gnt0 = 1; else exp_gnt1 = 1;
                a = (w == 0) ? int'(addr0) : int'(addr1);
                if (a < NUM_REGS) begin
                    exp_wr = 1;
                    exp_wa = ADDR_W'(a);
                    exp_ld = (w == 0) ? data0 : data1;
                end else begin
                    exp_err = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("gnt0", 32'(gnt0), 32'(exp_gnt0));
        chk("gnt1", 32'(gnt1), 32'(exp_gnt1));
        chk("err", 32'(err), 32'(exp_err));
        chk("WR", 32'(WR), 32'(exp_wr));
        chk("WA", 32'(WA), 32'(exp_wa));
        chk("LD_DATA", 32'(LD_DATA), 32'(exp_ld));
        chk("clr_busy", 32'(clr_busy), 32'(exp_busy));
        chk("dbg_state", 32'(dbg_state), exp_busy ? 32'(ST_CLEAR) : 32'(ST_IDLE));
    endtask

    task automatic check_rf();
        for (int i = 0; i < NUM_REGS; i++) chk($sformatf("row%0d", i), 32'(tb_rf[i]), 32'(m_rf[i]));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        #2 CLRN = 1'b0;
        req0 = 0; req1 = 0; clr_req = 0;
        #1;
        reset_model();
        check_outputs();
        check_rf();
        @(negedge CLK) CLRN = 1'b1;
    endtask

    int g0, g1, busy_cnt, gnt_at;

    initial begin
        reset_model();
        #1;
        check_outputs();
        @(negedge CLK) CLRN = 1'b1;

        // Contention right after reset: client 0 first, then strict alternation.
        req0 = 1; addr0 = 3'd0; data0 = 13'($urandom);
        req1 = 1; addr1 = 3'd1; data1 = 13'($urandom);
        g0 = 0; g1 = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 0) chk("first_gnt0", 32'(gnt0), 32'd1);
            g0 += int'(gnt0); g1 += int'(gnt1);
            if (gnt0) begin addr0 = 3'($urandom_range(0, 4)); data0 = 13'($urandom); end
            if (gnt1) begin addr1 = 3'($urandom_range(0, 4)); data1 = 13'($urandom); end
        end
        chk("contention_g0", 32'(g0), 32'd10);
        chk("contention_g1", 32'(g1), 32'd10);
        req0 = 0; req1 = 0;
        step();
        check_rf();

        // Single client write.
        req0 = 1; addr0 = 3'd3; data0 = 13'h1ABC;
        step();
        chk("single_gnt0", 32'(gnt0), 32'd1);
        chk("single_WR", 32'(WR), 32'd1);
        chk("single_WA", 32'(WA), 32'd3);
        chk("single_LD", 32'(LD_DATA), 32'h1ABC);
        req0 = 0;
        step();
        chk("single_row3", 32'(tb_rf[3]), 32'h1ABC);

        // Invalid address from client 1.
        req1 = 1; addr1 = 3'd6; data1 = 13'($urandom);
        step();
        chk("inv_gnt1", 32'(gnt1), 32'd1);
        chk("inv_err", 32'(err), 32'd1);
        chk("inv_WR", 32'(WR), 32'd0);
        req1 = 0;
        step();
        check_rf();

        // Preload rows with 1..5, then clear with a client-0 request pending.
        for (int r = 0; r < NUM_REGS; r++) begin
            req0 = 1; addr0 = ADDR_W'(r); data0 = DATA_W'(r + 1);
            step();
            req0 = 0;
            step();
        end
        check_rf();
        req0 = 1; addr0 = 3'd2; data0 = 13'h0AAA; clr_req = 1;
        busy_cnt = 0; gnt_at = -1;
        for (int c = 0; c < NUM_REGS + 2; c++) begin
            step();
            clr_req = 0;
            if (clr_busy) begin
                busy_cnt++;
                chk("clear_WA", 32'(WA), 32'(c));
            end
            if (gnt0 && gnt_at < 0) begin
                gnt_at = c;
                check_rf();
                req0 = 0;
            end
        end
        chk("clear_busy_cycles", 32'(busy_cnt), 32'(NUM_REGS));
        chk("clear_gnt_cycle", 32'(gnt_at), 32'(NUM_REGS));

        // Reset in the middle of traffic.
        req0 = 1; addr0 = 3'd4; data0 = 13'($urandom);
        req1 = 1; addr1 = 3'd1; data1 = 13'($urandom);
        step();
        step();
        async_reset();
        req0 = 1; req1 = 1;
        step();
        chk("post_reset_gnt0", 32'(gnt0), 32'd1);
        req0 = 0; req1 = 0;
        step();

        // Reset while clearing row 2.
        clr_req = 1;
        step();
        clr_req = 0;
        step();
        step();
        chk("abort_WA", 32'(WA), 32'd2);
        async_reset();
        for (int c = 0; c < 3; c++) step();
        check_rf();

        // Random traffic obeying the client handshake.
        for (int c = 0; c < 400; c++) begin
            if (req0 && gnt0) req0 = ($urandom_range(0, 1) == 1);
            else if (!req0) req0 = ($urandom_range(0, 9) < 4);
            if (req0 && !gnt0 == 1'b0 || (req0 && addr0 === 'x)) ;
            if (gnt0 || !req0) begin addr0 = 3'($urandom_range(0, 7)); data0 = 13'($urandom); end
            if (req1 && gnt1) req1 = ($urandom_range(0, 1) == 1);
            else if (!req1) req1 = ($urandom_range(0, 9) < 4);
            if (gnt1 || !req1) begin addr1 = 3'($urandom_range(0, 7)); data1 = 13'($urandom); end
            clr_req = ($urandom_range(0, 29) == 0);
            step();
            check_rf();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
